mux_arb_n: RTL and testbench

//   Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes.
//   It selects one input channel per cycle, either by an explicit select or by round-robin arbitration.
//   The chosen word is held in a single output register that stalls under back-pressure.
//   It is the generalised successor of the 8:1 single-bit registered mux and sits between

---
 rtl/mux_pkg.sv | 19 +
 rtl/rr_pick.sv | 30 +++
 rtl/mux_arb_n.sv | 93 +++++++++
 tb/tb_mux_arb_n.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared mode encodings, index typedef and width helper for mux_arb_n.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Wide enough to hold any channel index or channel count for range checks
  localparam int unsigned CH_IDX_MAX_W = 16;
  typedef logic [CH_IDX_MAX_W-1:0] ch_idx_t;

  // Index width for v channels, never less than one bit
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotated priority search: the first requester after ptr (mod N) wins.
module rr_pick
  import mux_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);

  logic [SELW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      idx = SELW'((32'(ptr) + k) % N);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel W-bit registered mux with valid/ready handshakes; explicit select or
// round-robin arbitration. Define MUX_PARITY_EN to add the registered out_par port.
module mux_arb_n
  import mux_pkg::*;
#(
  parameter  int unsigned N    = 8,
  parameter  int unsigned W    = 8,
  localparam int unsigned SELW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [N*W-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch
`ifdef MUX_PARITY_EN
  ,
  output logic            out_par
`endif
);

  localparam int unsigned NPAD = 32'd1 << SELW;

  logic [SELW-1:0] rr_ptr;
  logic [NPAD-1:0] valid_pad;
  logic            ld_c;
  logic            sel_vld_c;
  logic            rr_vld_c;
  logic [SELW-1:0] rr_idx_c;
  logic            gnt_vld_c;
  logic [SELW-1:0] gnt_idx_c;
  logic            gnt_c;
  logic [W-1:0]    gnt_data_c;

  rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_vld (rr_vld_c),
    .gnt_idx (rr_idx_c)
  );

  // Zero-padded valid vector so out-of-range select values read as idle
  assign valid_pad = NPAD'(in_valid);
  assign sel_vld_c = (ch_idx_t'(sel) < ch_idx_t'(N)) && valid_pad[sel];

  // Grant selection, handshake and data steering
  always_comb begin
    ld_c       = !out_valid || out_ready;
    gnt_vld_c  = sel_vld_c;
    gnt_idx_c  = sel;
    gnt_data_c = '0;
    in_ready   = '0;
    if (mode == MODE_RR) begin
      gnt_vld_c = rr_vld_c;
      gnt_idx_c = rr_idx_c;
    end
    gnt_c = ld_c && gnt_vld_c;
    for (int unsigned i = 0; i < N; i++) begin
      if (SELW'(i) == gnt_idx_c) gnt_data_c = in_data[i*W +: W];
    end
    // No handshake is offered while the block is held in reset
    if (gnt_c && rst) in_ready = N'(1) << gnt_idx_c;
  end

  // Output register and round-robin pointer; hold everything under back-pressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SELW'(N - 1);
`ifdef MUX_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else if (ld_c) begin
      out_valid <= gnt_vld_c;
      if (gnt_vld_c) begin
        out_data <= gnt_data_c;
        out_ch   <= gnt_idx_c;
        rr_ptr   <= gnt_idx_c;
`ifdef MUX_PARITY_EN
        out_par  <= ^gnt_data_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: an N=8 instance plus an N=6 instance for the
// out-of-range select and parity cases.
module tb_mux_arb_n;
  import mux_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  in_valid, in_ready;
  logic [63:0] in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;

  logic        mode6;
  logic [2:0]  sel6;
  logic [5:0]  in_valid6, in_ready6;
  logic [47:0] in_data6;
  logic        out_valid6, out_ready6;
  logic [7:0]  out_data6;
  logic [2:0]  out_ch6;
`ifdef MUX_PARITY_EN
  logic        out_par, out_par6;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] dv[8];
  logic [7:0] dv6[6];

  mux_arb_n #(.N(8), .W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
`ifdef MUX_PARITY_EN
    , .out_par(out_par)
`endif
  );

  mux_arb_n #(.N(6), .W(8)) dut6 (
    .clk(clk), .rst(rst), .mode(mode6), .sel(sel6),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6), .out_ch(out_ch6)
`ifdef MUX_PARITY_EN
    , .out_par(out_par6)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_data();
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = dv[i];
    for (int i = 0; i < 6; i++) in_data6[i*8 +: 8] = dv6[i];
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", out_valid); end
    n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h exp 00", out_data); end
    n_chk++; if (out_ch !== 3'd0) begin n_fail++; $display("FAIL rst_ch: got %0d exp 0", out_ch); end
    n_chk++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL rst_in_ready: got %h exp 00", in_ready); end
    n_chk++; if (out_valid6 !== 1'b0) begin n_fail++; $display("FAIL rst_valid6: got %b exp 0", out_valid6); end
`ifdef MUX_PARITY_EN
    n_chk++; if (out_par !== 1'b0) begin n_fail++; $display("FAIL rst_par: got %b exp 0", out_par); end
`endif
    step();
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid: got %b exp 0", out_valid); end
    in_valid = 8'h00;
    rst = 1'b1;
  endtask

  task automatic test_sel();
    mode = MODE_SEL; sel = 3'd3; in_valid = 8'hFF; out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 8'h08) begin n_fail++; $display("FAIL sel_in_ready: got %h exp 08", in_ready); end
    step();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sel_valid: got %b exp 1", out_valid); end
    n_chk++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL sel_data: got %h exp a5", out_data); end
    n_chk++; if (out_ch !== 3'd3) begin n_fail++; $display("FAIL sel_ch: got %0d exp 3", out_ch); end
  endtask

  task automatic test_reset_mid();
    #2;
    rst = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b exp 0", out_valid); end
    n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h exp 00", out_data); end
    n_chk++; if (out_ch !== 3'd0) begin n_fail++; $display("FAIL midrst_ch: got %0d exp 0", out_ch); end
    n_chk++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL midrst_in_ready: got %h exp 00", in_ready); end
    in_valid = 8'h00;
    step();
    rst = 1'b1;
  endtask

  task automatic test_rr_seq();
    logic [7:0] er;
    int ec;
    mode = MODE_RR; in_valid = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ec = k % 8;
      er = 8'd1 << ec;
      #1;
      n_chk++; if (in_ready !== er) begin n_fail++; $display("FAIL rr_in_ready[%0d]: got %h exp %h", k, in_ready, er); end
      step();
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b exp 1", k, out_valid); end
      n_chk++; if (out_ch !== 3'(ec)) begin n_fail++; $display("FAIL rr_ch[%0d]: got %0d exp %0d", k, out_ch, ec); end
      n_chk++; if (out_data !== dv[ec]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h exp %h", k, out_data, dv[ec]); end
    end
  endtask

  task automatic test_wrap();
    in_valid = 8'h80;
    step();
    n_chk++; if (out_ch !== 3'd7) begin n_fail++; $display("FAIL wrap_to7: got %0d exp 7", out_ch); end
    in_valid = 8'h81;
    step();
    n_chk++; if (out_ch !== 3'd0) begin n_fail++; $display("FAIL wrap_to0: got %0d exp 0", out_ch); end
    step();
    n_chk++; if (out_ch !== 3'd7) begin n_fail++; $display("FAIL wrap_back7: got %0d exp 7", out_ch); end
    in_valid = 8'h10;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++; if (out_valid !== 1'b1 || out_ch !== 3'd4) begin
        n_fail++; $display("FAIL single_ch[%0d]: got v=%b ch=%0d exp v=1 ch=4", k, out_valid, out_ch);
      end
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 8'hFF; out_ready = 1'b1;
    step();
    n_chk++; if (out_ch !== 3'd5) begin n_fail++; $display("FAIL bp_first_ch: got %0d exp 5", out_ch); end
    out_ready = 1'b0;
    #1;
    n_chk++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_in_ready: got %h exp 00", in_ready); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_chk++; if (out_valid !== 1'b1 || out_ch !== 3'd5 || out_data !== dv[5] || in_ready !== 8'h00) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h rdy=%h exp v=1 ch=5 d=%h rdy=00",
                 k, out_valid, out_ch, out_data, in_ready, dv[5]);
      end
    end
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 8'h40) begin n_fail++; $display("FAIL bp_release_rdy: got %h exp 40", in_ready); end
    step();
    n_chk++; if (out_valid !== 1'b1 || out_ch !== 3'd6 || out_data !== dv[6]) begin
      n_fail++; $display("FAIL bp_next: got v=%b ch=%0d d=%h exp v=1 ch=6 d=%h", out_valid, out_ch, out_data, dv[6]);
    end
    in_valid = 8'h00;
    step();
    n_chk++; if (out_valid !== 1'b0 || out_ch !== 3'd6 || out_data !== dv[6]) begin
      n_fail++; $display("FAIL no_grant: got v=%b ch=%0d d=%h exp v=0 ch=6 d=%h", out_valid, out_ch, out_data, dv[6]);
    end
  endtask

  task automatic test_n6();
    mode6 = MODE_SEL; sel6 = 3'd2; in_valid6 = 6'h3F; out_ready6 = 1'b1;
    #1;
    n_chk++; if (in_ready6 !== 6'h04) begin n_fail++; $display("FAIL n6_in_ready: got %h exp 04", in_ready6); end
    step();
    n_chk++; if (out_valid6 !== 1'b1 || out_data6 !== 8'h07 || out_ch6 !== 3'd2) begin
      n_fail++; $display("FAIL n6_sel2: got v=%b d=%h ch=%0d exp v=1 d=07 ch=2", out_valid6, out_data6, out_ch6);
    end
`ifdef MUX_PARITY_EN
    n_chk++; if (out_par6 !== 1'b1) begin n_fail++; $display("FAIL par_07: got %b exp 1", out_par6); end
`endif
    sel6 = 3'd5;
    step();
    n_chk++; if (out_valid6 !== 1'b1 || out_data6 !== 8'h03 || out_ch6 !== 3'd5) begin
      n_fail++; $display("FAIL n6_sel5: got v=%b d=%h ch=%0d exp v=1 d=03 ch=5", out_valid6, out_data6, out_ch6);
    end
`ifdef MUX_PARITY_EN
    n_chk++; if (out_par6 !== 1'b0) begin n_fail++; $display("FAIL par_03: got %b exp 0", out_par6); end
`endif
    sel6 = 3'd6;
    #1;
    n_chk++; if (in_ready6 !== 6'h00) begin n_fail++; $display("FAIL n6_oor_rdy: got %h exp 00", in_ready6); end
    step();
    n_chk++; if (out_valid6 !== 1'b0 || out_data6 !== 8'h03 || out_ch6 !== 3'd5) begin
      n_fail++; $display("FAIL n6_oor: got v=%b d=%h ch=%0d exp v=0 d=03 ch=5", out_valid6, out_data6, out_ch6);
    end
  endtask

  initial begin
    rst = 1'b0;
    mode = MODE_SEL; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
    mode6 = MODE_SEL; sel6 = 3'd0; in_valid6 = 6'h00; out_ready6 = 1'b0;
    for (int i = 0; i < 8; i++) dv[i] = 8'hC0 | 8'(i);
    dv[3] = 8'hA5;
    for (int i = 0; i < 6; i++) dv6[i] = 8'h50 | 8'(i);
    dv6[2] = 8'h07;
    dv6[5] = 8'h03;
    load_data();

    test_reset();
    test_sel();
    test_reset_mid();
    test_rr_seq();
    test_wrap();
    test_back_to_back();
    test_n6();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
